// File: rtl/mult_div_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_pkg
// Shared definitions for the sequential multiply/divide unit.
//   - MD_WIDTH / MD_ITER : default operand width and iteration count
//   - md_state_e         : control FSM states
//   - RES_*              : result-select codes, shared with the HI/LO register block
// -----------------------------------------------------------------------------
package mult_div_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITER  = MD_WIDTH;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } md_state_e;

    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_MULT = 2'd1;
    localparam logic [1:0] RES_DIV  = 2'd2;

endpackage

// File: rtl/mult_div_unit_booth_step.sv
// -----------------------------------------------------------------------------
// booth_step
// One combinational radix-2 Booth step on {acc, q, q_-1}: add, subtract or
// keep the multiplicand, then arithmetic shift right by one.
// The accumulator carries one guard bit so that subtracting the most
// negative multiplicand cannot overflow.
// Ports:
//   acc_i  [WIDTH:0]   accumulator (with guard bit)
//   q_i    [WIDTH-1:0] multiplier / low product bits
//   qm1_i              Booth history bit q_-1
//   m_i    [WIDTH-1:0] multiplicand
//   acc_o, q_o, qm1_o  register values after the step
// -----------------------------------------------------------------------------
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             qm1_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] q_o,
    output logic             qm1_o
);

    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;

    assign m_ext = {m_i[WIDTH-1], m_i};

    always_comb begin
        sum = acc_i;
        case ({q_i[0], qm1_i})
            2'b01:   sum = acc_i + m_ext;
            2'b10:   sum = acc_i - m_ext;
            default: sum = acc_i;
        endcase
    end

    // Arithmetic shift right of the whole {acc, q, q_-1} register.
    assign {acc_o, q_o, qm1_o} = {sum[WIDTH], sum, q_i};

endmodule

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Sequential signed multiply/divide for the multicycle MIPS datapath.
// MULT: radix-2 Booth, one step per cycle. DIV: restoring division on operand
// magnitudes, one quotient bit per cycle, followed by a sign-fix cycle.
// Fixed latency of 34 cycles from the start edge; done pulses for one cycle
// with the new HI/LO.
//
// Optional feature macro: MULT_DIV_ZERO_EXC_EN
//   defined   : divide by zero completes one cycle after start with done and
//               div_zero high, HI/LO untouched.
//   undefined : div_zero tied low; divide by zero runs the full sequence and
//               yields hi = src_a, lo = all ones.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   mult_start  one-cycle pulse, start signed multiply (wins over div_start)
//   div_start   one-cycle pulse, start signed divide
//   src_a       multiplicand / dividend
//   src_b       multiplier / divisor
//   hi_out      product high word / remainder
//   lo_out      product low word / quotient
//   busy        operation in flight
//   done        one-cycle completion pulse
//   div_zero    divide-by-zero flag (optional feature)
//
// State | meaning
// IDLE  | waiting for a start pulse
// MULT  | Booth step per cycle, ITER cycles
// DIV   | restoring quotient bit per cycle, ITER cycles
// FIX   | apply quotient/remainder signs (no-op for multiply)
// DONE  | publish HI/LO and raise done on the next edge
// -----------------------------------------------------------------------------
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(ITER + 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       op_q;
    logic [WIDTH:0]   acc_q;      // Booth accumulator / division remainder
    logic [WIDTH-1:0] q_q;        // multiplier / quotient being built
    logic             qm1_q;
    logic [WIDTH-1:0] m_q;        // multiplicand / divisor magnitude
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;
    logic             busy_c;

    logic [WIDTH:0]   booth_acc;
    logic [WIDTH-1:0] booth_q;
    logic             booth_qm1;

    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_ok;

`ifdef MULT_DIV_ZERO_EXC_EN
    logic             dz_q;
    logic             div_zero_q;
`endif

    booth_step #(.WIDTH(WIDTH)) u_booth (
        .acc_i (acc_q),
        .q_i   (q_q),
        .qm1_i (qm1_q),
        .m_i   (m_q),
        .acc_o (booth_acc),
        .q_o   (booth_q),
        .qm1_o (booth_qm1)
    );

    // Restoring step: shift the next dividend bit into the remainder and
    // keep the difference only when it does not go negative.
    assign div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, m_q};
    assign div_ok    = ~div_diff[WIDTH+1];

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mult_start) begin
                    state_d = MULT;
                end else if (div_start) begin
`ifdef MULT_DIV_ZERO_EXC_EN
                    state_d = (src_b == '0) ? DONE : DIV;
`else
                    state_d = DIV;
`endif
                end
            end
            MULT, DIV: if (cnt_q == '0) state_d = FIX;
            FIX:       state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        busy_c = (state_q != IDLE);
    end

    assign busy   = busy_c;
    assign done   = done_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;
`ifdef MULT_DIV_ZERO_EXC_EN
    assign div_zero = div_zero_q;
`else
    assign div_zero = 1'b0;
`endif

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            op_q       <= RES_NONE;
            acc_q      <= '0;
            q_q        <= '0;
            qm1_q      <= 1'b0;
            m_q        <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
`ifdef MULT_DIV_ZERO_EXC_EN
            dz_q       <= 1'b0;
            div_zero_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef MULT_DIV_ZERO_EXC_EN
            div_zero_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (mult_start) begin
                        op_q  <= RES_MULT;
                        cnt_q <= CNT_W'(ITER - 1);
                        acc_q <= '0;
                        q_q   <= src_b;
                        qm1_q <= 1'b0;
                        m_q   <= src_a;
`ifdef MULT_DIV_ZERO_EXC_EN
                        dz_q  <= 1'b0;
`endif
                    end else if (div_start) begin
                        op_q      <= RES_DIV;
                        cnt_q     <= CNT_W'(ITER - 1);
                        acc_q     <= '0;
                        q_q       <= src_a[WIDTH-1] ? -src_a : src_a;
                        qm1_q     <= 1'b0;
                        m_q       <= src_b[WIDTH-1] ? -src_b : src_b;
                        // A zero divisor leaves the all-ones quotient unsigned.
                        neg_quo_q <= (src_a[WIDTH-1] ^ src_b[WIDTH-1]) && (src_b != '0);
                        neg_rem_q <= src_a[WIDTH-1];
`ifdef MULT_DIV_ZERO_EXC_EN
                        dz_q      <= (src_b == '0);
`endif
                    end
                end
                MULT: begin
                    acc_q <= booth_acc;
                    q_q   <= booth_q;
                    qm1_q <= booth_qm1;
                    cnt_q <= cnt_q - 1'b1;
                end
                DIV: begin
                    acc_q <= div_ok ? div_diff[WIDTH:0] : div_shift;
                    q_q   <= {q_q[WIDTH-2:0], div_ok};
                    cnt_q <= cnt_q - 1'b1;
                end
                FIX: begin
                    if (op_q == RES_DIV) begin
                        q_q   <= neg_quo_q ? -q_q : q_q;
                        acc_q <= {1'b0, (neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0])};
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
`ifdef MULT_DIV_ZERO_EXC_EN
                    div_zero_q <= dz_q;
                    if (!dz_q) begin
                        hi_q <= acc_q[WIDTH-1:0];
                        lo_q <= q_q;
                    end
`else
                    hi_q <= acc_q[WIDTH-1:0];
                    lo_q <= q_q;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Sequential signed multiply/divide unit for the multicycle MIPS datapath.
- Sits directly downstream of the MDSrcA/MDSrcB operand muxes: src_a is the mux output (RegA or MDR), src_b is the second operand.
- Produces 64-bit HI/LO results for MULT and DIV, consumed by the HI/LO registers and mfhi/mflo paths.
- Control FSM starts it with a one-cycle pulse and waits for done.

Parameters:
- WIDTH, 32, operand width; results are WIDTH each for HI and LO.
- ITER, WIDTH, number of iteration cycles per operation.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-low; 0 clears all state immediately.
- mult_start, input, 1, one-cycle pulse; starts a signed multiply.
- div_start, input, 1, one-cycle pulse; starts a signed divide.
- src_a, input, WIDTH, multiplicand or dividend.
- src_b, input, WIDTH, multiplier or divisor.
- hi_out, output, WIDTH, MULT: product[63:32]; DIV: remainder.
- lo_out, output, WIDTH, MULT: product[31:0]; DIV: quotient.
- busy, output, 1, high while an operation is in flight.
- done, output, 1, one-cycle completion pulse.
- div_zero, output, 1, divide-by-zero flag; only driven under the optional feature.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, iteration counter=0, hi_out=0, lo_out=0, busy=0, done=0, div_zero=0, operand registers=0.
- States: IDLE, MULT, DIV, FIX, DONE.
- IDLE:
  - If mult_start=1 at edge E0: latch src_a and src_b, go to MULT.
  - Else if div_start=1 at E0: latch operands, go to DIV.
  - If both are high, mult_start wins.
- MULT: radix-2 Booth, one step per cycle, edges E1..E32. After the 32nd step, go to FIX.
- DIV: restoring division on operand magnitudes, one quotient bit per cycle, edges E1..E32. After the 32nd step, go to FIX.
- FIX (edge E33):
  - MULT: no-op.
  - DIV: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
- DONE (entered at edge E34):
  - hi_out/lo_out are registered at E34.
  - done=1 for that single cycle, then return to IDLE.
  - Latency is fixed at 34 cycles from the start edge for both operations.
- busy=1 from E0 up to E34; busy=0 in the DONE cycle.
- Start pulses arriving while busy=1 are ignored; no queueing.
- hi_out/lo_out hold their value until the next completion and do not change mid-operation.
- Operands are latched at E0; later changes on src_a/src_b have no effect.
- Results follow MIPS semantics: the quotient truncates toward zero, and the remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0x00000000, with no flag.
- Reset asserted mid-operation aborts the operation; outputs go to 0 and no done pulse is produced.

Optional Feature:
- Macro: MULT_DIV_ZERO_EXC_EN.
- Defined:
  - div_start with src_b=0 goes IDLE→DONE at E1.
  - done=1 and div_zero=1 together for one cycle.
  - hi_out/lo_out are unchanged; the control FSM uses div_zero to raise the divide-by-zero exception.
- Undefined:
  - div_zero is tied to 0.
  - A divide by zero runs the full 34 cycles and produces hi=src_a, lo=0xFFFFFFFF.

Decomposition:
- Shared package mult_div_pkg holds:
  - State enum (IDLE, MULT, DIV, FIX, DONE).
  - WIDTH/ITER constants.
  - Result-select constants reused by the HI/LO register block.
- One natural sub-module: booth_step, the combinational single Booth step (add/sub/none plus arithmetic shift) on {acc, q, q_-1}. The divide datapath stays inline.

Test Plan:
- mult_start, a=7, b=-3 → at E34: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high E0..E33.
- mult_start, a=0x7FFFFFFF, b=0x7FFFFFFF → hi=0x3FFFFFFF, lo=0x00000001 after 34 cycles.
- div_start, a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); a=0x80000000, b=-1 → lo=0x80000000, hi=0.
- div_start, b=0:
  - With MULT_DIV_ZERO_EXC_EN: done and div_zero both high at E1, hi/lo unchanged.
  - Without it: done at E34 with hi=a, lo=0xFFFFFFFF.
- Both starts in the same cycle → multiply performed. A second div_start at E10 is ignored, and the first result is unaffected.
- reset driven low at E15 of a DIV → outputs 0 immediately, state IDLE, no done. A new mult after reset release completes normally at E34.
